i2c_master: RTL and testbench

- Single-byte I2C bus master for one read or one write per transaction.
- Generates START, sends a 7-bit address plus the R/W bit, checks the slave ACK, then either transmits one byte (write) or receives one byte and NACKs it (read), and finishes with STOP.
- Sits between a simple local request interface (start/addr/rw/data) and the external SCL/SDA pins.

---
 rtl/i2c_master_pkg.sv | 27 ++
 rtl/i2c_scl_gen.sv | 52 +++++
 rtl/i2c_master.sv | 171 +++++++++++++++++
 tb/tb_i2c_master.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_pkg.sv
// Shared definitions for the single-byte I2C master: FSM states, SCL quarter
// phases and the width of the per-byte bit counter.
package i2c_master_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ACK_A,
        WRITE,
        ACK_W,
        READ,
        NACK,
        STOP
    } state_e;

    // Quarters of one SCL bit period: Q0/Q1 have SCL low, Q2/Q3 have SCL high.
    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } phase_e;

    localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/i2c_scl_gen.sv
// SCL timebase: QDIV clocks per quarter, four quarters per bit. Emits the
// current quarter, a tick on the last clock of each bit and a mid-high sample strobe.
module i2c_scl_gen
    import i2c_master_pkg::*;
#(
    parameter int QDIV = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   run_i,
    output phase_e scl_phase_o,
    output logic   bit_end_o,
    output logic   sample_l_o
);

    localparam int               CNT_W   = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QDIV - 1);

    logic [CNT_W-1:0] qcnt_q, qcnt_d;
    phase_e           phase_q, phase_d;

    // NOTE: every signal driven from always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        qcnt_d  = qcnt_q;
        phase_d = phase_q;
        if (!run_i) begin
            qcnt_d  = '0;
            phase_d = Q0;
        end else if (qcnt_q == CNT_MAX) begin
            qcnt_d  = '0;
            phase_d = phase_e'(phase_q + 2'd1);
        end else begin
            qcnt_d = qcnt_q + 1'b1;
        end
    end

    // NOTE: state registers take non-blocking assignments and a synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qcnt_q  <= '0;
            phase_q <= Q0;
        end else begin
            qcnt_q  <= qcnt_d;
            phase_q <= phase_d;
        end
    end

    assign scl_phase_o = phase_q;
    assign bit_end_o   = run_i && (phase_q == Q3) && (qcnt_q == CNT_MAX);
    assign sample_l_o  = run_i && (phase_q == Q3) && (qcnt_q == '0);

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+R/W, ACK check, one data byte out or in
// (reads are NACKed), STOP. Define I2C_TSDA_IN_EN to sample SDA from t_sda instead of the pin.
module i2c_master
    import i2c_master_pkg::*;
#(
    parameter int QDIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] data_w,
    input  logic       start,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       scl,
    inout  wire        sda,
    input  logic       t_sda,
    output logic       busy,
    output logic       erro_addr
);

    state_e                 state_q, state_d;
    logic [7:0]             shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   rw_q, rw_d;
    logic [7:0]             data_q, data_d;
    logic                   erro_q, erro_d;
    logic [7:0]             data_out_q, data_out_d;
    logic                   valid_q, valid_d;

    phase_e scl_phase;
    logic   bit_end;
    logic   sample_l;
    logic   en_sda;
    logic   sda_o;
    logic   sda_in;
    logic   last_bit;

`ifdef I2C_TSDA_IN_EN
    assign sda_in = t_sda;
`else
    logic unused_t_sda;
    assign unused_t_sda = t_sda;
    assign sda_in       = sda;
`endif

    i2c_scl_gen #(
        .QDIV (QDIV)
    ) u_scl_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .run_i       (state_q != IDLE),
        .scl_phase_o (scl_phase),
        .bit_end_o   (bit_end),
        .sample_l_o  (sample_l)
    );

    assign last_bit = (bit_cnt_q == BIT_CNT_W'(7));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        rw_d       = rw_q;
        data_d     = data_q;
        erro_d     = erro_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        en_sda     = 1'b0;
        sda_o      = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = START;
                    rw_d      = rw;
                    data_d    = data_w;
                    shift_d   = {addr, rw};
                    bit_cnt_d = '0;
                    erro_d    = 1'b0;
                end
            end
            START: begin
                en_sda = 1'b1;
                sda_o  = (scl_phase != Q3);
                if (bit_end) state_d = ADDR;
            end
            ADDR, WRITE: begin
                en_sda = 1'b1;
                sda_o  = shift_q[7];
                if (bit_end) begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (last_bit) state_d = (state_q == ADDR) ? ACK_A : ACK_W;
                end
            end
            ACK_A: begin
                // erro_q was cleared at accept, so it holds the sampled ACK by bit_end.
                if (sample_l) erro_d = sda_in;
                if (bit_end) begin
                    if (erro_q) begin
                        state_d = STOP;
                    end else if (rw_q) begin
                        state_d = READ;
                    end else begin
                        state_d = WRITE;
                        shift_d = data_q;
                    end
                end
            end
            ACK_W: begin
                if (bit_end) state_d = STOP;
            end
            READ: begin
                if (sample_l) begin
                    shift_d = {shift_q[6:0], sda_in};
                    if (last_bit) begin
                        data_out_d = {shift_q[6:0], sda_in};
                        valid_d    = 1'b1;
                    end
                end
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (last_bit) state_d = NACK;
                end
            end
            NACK: begin
                en_sda = 1'b1;
                sda_o  = 1'b1;
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                en_sda = 1'b1;
                sda_o  = (scl_phase == Q3);
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            rw_q       <= 1'b0;
            data_q     <= '0;
            erro_q     <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            rw_q       <= rw_d;
            data_q     <= data_d;
            erro_q     <= erro_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

    assign scl       = (state_q == IDLE) || scl_phase[1];
    assign sda       = en_sda ? sda_o : 1'bz;
    assign busy      = (state_q != IDLE);
    assign erro_addr = erro_q;
    assign data_out  = data_out_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: a bit-period level model of the bus
// predicts SCL/SDA/busy/valid/data/error every cycle; the bench also plays the slave.
`ifndef I2C_TSDA_IN_EN
`define I2C_TSDA_IN_EN
`endif

module tb_i2c_master;

    localparam int QDIV = 3;
    localparam int BP   = 4 * QDIV;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [6:0] addr   = '0;
    logic       rw     = 1'b0;
    logic [7:0] data_w = '0;
    logic       start  = 1'b0;
    logic       t_sda  = 1'b1;
    logic [7:0] data_out;
    logic       valid_out;
    logic       scl;
    logic       busy;
    logic       erro_addr;
    wire        sda;

    // Slave side of the bus: drives only in bit periods the master releases.
    logic dev_oe  = 1'b0;
    logic dev_val = 1'b1;
    assign sda = dev_oe ? dev_val : 1'bz;
    pullup pu_sda (sda);

    always #5 clk = ~clk;

    i2c_master #(
        .QDIV (QDIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .rw        (rw),
        .data_w    (data_w),
        .start     (start),
        .data_out  (data_out),
        .valid_out (valid_out),
        .scl       (scl),
        .sda       (sda),
        .t_sda     (t_sda),
        .busy      (busy),
        .erro_addr (erro_addr)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave behaviour for the next accepted transaction.
    logic       nxt_ack   = 1'b0;
    logic       nxt_wack  = 1'b0;
    logic [7:0] nxt_rdata = '0;

    // Reference model: one transaction is a list of bit periods, offset m_t from the accept edge.
    bit         m_init = 1'b0;
    bit         m_busy = 1'b0;
    int         m_t    = 0;
    int         m_len  = 0;
    logic [6:0] m_addr = '0;
    logic       m_rw   = 1'b0;
    logic [7:0] m_wdata = '0;
    logic       m_ack  = 1'b0;
    logic       m_wack = 1'b0;
    logic [7:0] m_rdata = '0;
    logic [7:0] m_dout = '0;
    logic       m_erro = 1'b0;
    logic       m_valid = 1'b0;

    // Who owns SDA at offset t, and the level it should carry.
    function automatic void bit_info(input int t, output logic drv, output logic v);
        int         b = t / BP;
        int         q = (t % BP) / QDIV;
        logic [7:0] a_byte = {m_addr, m_rw};
        drv = 1'b1;
        v   = 1'b1;
        if (b == 0) begin
            v = (q != 3);
        end else if (b == m_len / BP - 1) begin
            v = (q == 3);
        end else if (b <= 8) begin
            v = a_byte[8 - b];
        end else if (b == 9) begin
            drv = 1'b0;
            v   = m_ack;
        end else if (!m_rw) begin
            if (b <= 17) v = m_wdata[17 - b];
            else begin
                drv = 1'b0;
                v   = m_wack;
            end
        end else begin
            if (b <= 17) begin
                drv = 1'b0;
                v   = m_rdata[17 - b];
            end else begin
                v = 1'b1;
            end
        end
    endfunction

    always @(posedge clk) begin
        logic drv, v;
        if (!rst_n) begin
            m_init = 1'b1;
            m_busy = 1'b0;
            m_erro = 1'b0;
            m_dout = '0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy  = 1'b1;
                m_t     = 0;
                m_addr  = addr;
                m_rw    = rw;
                m_wdata = data_w;
                m_ack   = nxt_ack;
                m_wack  = nxt_wack;
                m_rdata = nxt_rdata;
                m_len   = (nxt_ack ? 11 : 20) * BP;
                m_erro  = 1'b0;
            end
        end else begin
            m_t++;
            if (m_t == m_len) m_busy = 1'b0;
        end
        m_valid = m_busy && m_rw && !m_ack && (m_t == 17 * BP + 3 * QDIV + 1);
        if (m_valid) m_dout = m_rdata;
        if (m_busy && m_ack && (m_t == 9 * BP + 3 * QDIV + 1)) m_erro = 1'b1;
        #1;
        if (m_busy) begin
            bit_info(m_t, drv, v);
            dev_oe  = !drv;
            dev_val = v;
        end else begin
            dev_oe = 1'b0;
        end
        t_sda = dev_oe ? dev_val : 1'b1;
    end

    // Per-cycle compare plus observations used by the literal checks.
    int         busy_cnt  = 0;
    int         valid_cnt = 0;
    int         busy_rise = 0;
    logic       prev_busy = 1'b0;
    logic [7:0] obs_addr  = '0;
    logic [7:0] obs_data  = '0;
    logic       obs_nack  = 1'b0;
    logic       erro_first = 1'b0;

    always @(negedge clk) begin
        logic drv, v, exp_scl, exp_sda;
        int   b;
        if (m_init) begin
            exp_scl = 1'b1;
            exp_sda = 1'b1;
            if (m_busy) begin
                exp_scl = ((m_t % BP) >= 2 * QDIV);
                bit_info(m_t, drv, v);
                exp_sda = v;
            end
            check("scl", scl, exp_scl);
            check("sda", sda, exp_sda);
            check("busy", busy, m_busy);
            check("valid_out", valid_out, m_valid);
            check("data_out", data_out, m_dout);
            check("erro_addr", erro_addr, m_erro);
        end
        if (busy) busy_cnt++;
        if (valid_out) valid_cnt++;
        if (busy && !prev_busy) busy_rise++;
        prev_busy = busy;
        if (m_busy && (m_t % BP) == 2 * QDIV) begin
            b = m_t / BP;
            if (b >= 1 && b <= 8) obs_addr = {obs_addr[6:0], sda};
            if (b >= 10 && b <= 17) obs_data = {obs_data[6:0], sda};
            if (b == 18) obs_nack = sda;
        end
    end

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                           input logic ack, input logic wack, input logic [7:0] rd);
        int n;
        addr      = a;
        rw        = r;
        data_w    = d;
        nxt_ack   = ack;
        nxt_wack  = wack;
        nxt_rdata = rd;
        busy_cnt  = 0;
        valid_cnt = 0;
        start     = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        erro_first = erro_addr;
        n = 0;
        // Scramble every request input while busy; none of it may matter.
        while (busy && n < 30 * BP) begin
            if (m_busy && m_t < m_len - BP) begin
                start  = 1'($urandom);
                addr   = 7'($urandom);
                rw     = 1'($urandom);
                data_w = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("txn_finished", busy, 1'b0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle", busy, 1'b0);
    endtask

    initial begin
        int n;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_scl", scl, 1'b1);
        check("rst_sda", sda, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", valid_out, 1'b0);
        check("rst_data_out", data_out, 8'h00);
        check("rst_erro", erro_addr, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Read 0x10, slave returns all zeros. 20 bits * 12 clocks = 240 busy cycles.
        run_txn(7'h10, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);
        check("rd10_addr_bits", obs_addr, 8'h21);
        check("rd10_valid_cnt", valid_cnt, 1);
        check("rd10_data", data_out, 8'h00);
        check("rd10_erro", erro_addr, 1'b0);
        check("rd10_nack_bit", obs_nack, 1'b1);
        check("rd10_busy_len", busy_cnt, 240);

        // Write 0xA5 to 0x59.
        run_txn(7'h59, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00);
        check("wr59_addr_bits", obs_addr, 8'hB2);
        check("wr59_data_bits", obs_data, 8'hA5);
        check("wr59_valid_cnt", valid_cnt, 0);
        check("wr59_busy_len", busy_cnt, 240);

        // Read 0x59, slave returns 1,0,1,0,0,1,1,0.
        run_txn(7'h59, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA6);
        check("rd59_data", data_out, 8'hA6);
        check("rd59_valid_cnt", valid_cnt, 1);

        // Address NACK: 11 bits * 12 clocks = 132 busy cycles.
        run_txn(7'h33, 1'b1, 8'h00, 1'b1, 1'b0, 8'h5A);
        check("nack_erro", erro_addr, 1'b1);
        check("nack_busy_len", busy_cnt, 132);
        check("nack_valid_cnt", valid_cnt, 0);
        check("nack_data_kept", data_out, 8'hA6);

        run_txn(7'h22, 1'b0, 8'h81, 1'b0, 1'b1, 8'h00);
        check("erro_cleared_on_start", erro_first, 1'b0);

        // start held high across three back-to-back transactions (241 cycles apart).
        addr      = 7'h2B;
        rw        = 1'b0;
        data_w    = 8'h3C;
        nxt_ack   = 1'b0;
        nxt_wack  = 1'b0;
        busy_rise = 0;
        start     = 1'b1;
        repeat (2 * (20 * BP + 1) + 1) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(30 * BP);
        check("b2b_txn_count", busy_rise, 3);

        for (int i = 0; i < 24; i++) begin
            run_txn(7'($urandom), 1'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom));
        end

        run_txn(7'h3C, 1'b1, 8'h00, 1'b0, 1'b0, 8'h5A);
        check("rd3c_data", data_out, 8'h5A);

        // Reset in the middle of the READ byte.
        addr      = 7'h4E;
        rw        = 1'b1;
        nxt_ack   = 1'b0;
        nxt_rdata = 8'hC3;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (m_t != 12 * BP + 5 && n < 20 * BP) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_read_busy", busy, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_scl", scl, 1'b1);
        check("abort_sda", sda, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_valid", valid_out, 1'b0);
        check("abort_data_out", data_out, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(7'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 8'h96);
        check("post_reset_data", data_out, 8'h96);
        check("post_reset_valid_cnt", valid_cnt, 1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
